// File: rtl/dreg_bus_sequencer.sv
// Bus-master sequencer for a bank of tri-state data registers sharing one bus.
// Issues load/output enables so that every transfer is followed by a dead gap with no driver.
module dreg_bus_sequencer #(
    parameter int NREG = 4,
    parameter int DW   = 2,
    parameter int IW   = 2,
    parameter int TURN = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [IW-1:0]   cmd_src,
    input  logic [IW-1:0]   cmd_dst,
    input  logic [DW-1:0]   cmd_imm,
    output logic [NREG-1:0] le,
    output logic [NREG-1:0] oe_n,
    output logic            bus_drive_en,
    output logic [DW-1:0]   bus_out,
    input  logic [DW-1:0]   bus_in,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_data,
    input  logic            rsp_ready,
    output logic            err
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        LOAD,
        RELEASE,
        RESP
    } state_t;

    localparam logic [1:0]  OP_NOP   = 2'd0;
    localparam logic [1:0]  OP_LOADI = 2'd1;
    localparam logic [1:0]  OP_MOVE  = 2'd2;
    localparam logic [1:0]  OP_READ  = 2'd3;
    localparam logic [IW:0] NREG_L   = (IW+1)'(NREG);
    localparam logic [1:0]  TURN_L   = 2'(TURN - 1);

    state_t          state, state_nx;
    logic [1:0]      op_q, op_nx;
    logic [IW-1:0]   src_q, src_nx;
    logic [IW-1:0]   dst_q, dst_nx;
    logic [DW-1:0]   imm_q, imm_nx;
    logic [1:0]      turn_cnt, turn_cnt_nx;
    logic            accept;
    logic            bad_idx;

    logic [NREG-1:0] le_nx;
    logic [NREG-1:0] oe_n_nx;
    logic            drive_nx;
    logic [DW-1:0]   bus_out_nx;
    logic            rsp_valid_nx;
    logic [DW-1:0]   rsp_data_nx;
    logic            err_nx;
    logic            cmd_ready_nx;

    // Only the indices an opcode actually uses are range-checked.
    always_comb begin
        bad_idx = 1'b0;
        unique case (cmd_op)
            OP_LOADI: bad_idx = ({1'b0, cmd_dst} >= NREG_L);
            OP_MOVE:  bad_idx = ({1'b0, cmd_src} >= NREG_L) || ({1'b0, cmd_dst} >= NREG_L);
            OP_READ:  bad_idx = ({1'b0, cmd_src} >= NREG_L);
            default:  bad_idx = 1'b0;
        endcase
    end

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        state_nx    = state;
        op_nx       = op_q;
        src_nx      = src_q;
        dst_nx      = dst_q;
        imm_nx      = imm_q;
        turn_cnt_nx = turn_cnt;
        err_nx      = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (bad_idx) begin
                        err_nx = 1'b1;
                    end else if (cmd_op != OP_NOP) begin
                        state_nx = DRIVE;
                        op_nx    = cmd_op;
                        src_nx   = cmd_src;
                        dst_nx   = cmd_dst;
                        imm_nx   = cmd_imm;
                    end
                end
            end
            DRIVE: state_nx = LOAD;
            LOAD: begin
                state_nx    = RELEASE;
                turn_cnt_nx = TURN_L;
            end
            RELEASE: begin
                if (turn_cnt == 2'd0) begin
                    state_nx = (op_q == OP_READ) ? RESP : IDLE;
                end else begin
                    turn_cnt_nx = turn_cnt - 2'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with the state.
    always_comb begin
        le_nx      = '0;
        oe_n_nx    = '1;
        drive_nx   = 1'b0;
        bus_out_nx = '0;
        if (state_nx == DRIVE || state_nx == LOAD) begin
            if (op_nx == OP_LOADI) begin
                drive_nx   = 1'b1;
                bus_out_nx = imm_nx;
            end else begin
                for (int i = 0; i < NREG; i++) begin
                    if (src_nx == IW'(i)) begin
                        oe_n_nx[i] = 1'b0;
                    end
                end
            end
            if (state_nx == LOAD && op_nx != OP_READ) begin
                for (int i = 0; i < NREG; i++) begin
                    if (dst_nx == IW'(i)) begin
                        le_nx[i] = 1'b1;
                    end
                end
            end
        end
        cmd_ready_nx = (state_nx == IDLE);
        rsp_valid_nx = (state_nx == RESP);
        rsp_data_nx  = (state == LOAD && op_q == OP_READ) ? bus_in : rsp_data;
    end

    // Control and output register stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            turn_cnt     <= 2'd0;
            le           <= '0;
            oe_n         <= '1;
            bus_drive_en <= 1'b0;
            bus_out      <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            err          <= 1'b0;
            cmd_ready    <= 1'b0;
        end else begin
            state        <= state_nx;
            turn_cnt     <= turn_cnt_nx;
            le           <= le_nx;
            oe_n         <= oe_n_nx;
            bus_drive_en <= drive_nx;
            bus_out      <= bus_out_nx;
            rsp_valid    <= rsp_valid_nx;
            rsp_data     <= rsp_data_nx;
            err          <= err_nx;
            cmd_ready    <= cmd_ready_nx;
        end
    end

    // Captured command fields carry no control meaning outside a transfer.
    always_ff @(posedge clk) begin
        op_q  <= op_nx;
        src_q <= src_nx;
        dst_q <= dst_nx;
        imm_q <= imm_nx;
    end

endmodule

// File: tb/tb_dreg_bus_sequencer.sv
// Randomized bench for dreg_bus_sequencer: a modelled tri-state register bank on the bus,
// a transaction-level register-file model, and per-cycle bus-safety checks.
module tb_dreg_bus_sequencer;

    localparam int NREG = 3;
    localparam int DW   = 2;
    localparam int IW   = 2;
    localparam int TURN = 2;
    localparam logic [NREG-1:0] ALL1 = '1;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [IW-1:0]   cmd_src;
    logic [IW-1:0]   cmd_dst;
    logic [DW-1:0]   cmd_imm;
    logic [NREG-1:0] le;
    logic [NREG-1:0] oe_n;
    logic            bus_drive_en;
    logic [DW-1:0]   bus_out;
    logic [DW-1:0]   bus_in;
    logic            rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            rsp_ready;
    logic            err;

    dreg_bus_sequencer #(.NREG(NREG), .DW(DW), .IW(IW), .TURN(TURN)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
        .le(le), .oe_n(oe_n), .bus_drive_en(bus_drive_en), .bus_out(bus_out),
        .bus_in(bus_in), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .err(err)
    );

    always #5 clk = ~clk;

    // Register bank and bus resolution as seen by the physical registers.
    logic [DW-1:0] bank  [NREG];
    logic [DW-1:0] model [NREG];

    always_comb begin
        bus_in = '0;
        if (bus_drive_en) bus_in = bus_out;
        for (int i = 0; i < NREG; i++) begin
            if (!oe_n[i]) bus_in = bank[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (le[i]) bank[i] <= bus_in;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bus-safety checks sampled every cycle while out of reset.
    int drv_prev = 0;
    int gap = 100;
    always @(negedge clk) begin : safety
        int drivers;
        int cur;
        if (!reset) begin
            drv_prev = 0;
            gap = 100;
        end else begin
            drivers = int'(bus_drive_en) + $countones(~oe_n);
            cur = 0;
            if (bus_drive_en) cur = 1;
            for (int i = 0; i < NREG; i++) if (!oe_n[i]) cur = 2 + i;
            check_eq("contention", 32'(drivers <= 1), 32'(1));
            check_eq("le_onehot0", 32'($countones(le) <= 1), 32'(1));
            check_eq("le_without_driver", 32'(le != '0 && drivers == 0), 32'(0));
            if (cur != 0 && drv_prev != 0 && cur != drv_prev)
                check_eq("driver_switch_no_gap", 32'(cur), 32'(drv_prev));
            if (cur != 0 && drv_prev == 0)
                check_eq("release_gap", 32'(gap >= TURN), 32'(1));
            gap = (cur == 0) ? gap + 1 : 0;
            drv_prev = cur;
        end
    end

    task automatic junk();
        cmd_valid = 1'($urandom);
        cmd_op    = 2'($urandom);
        cmd_src   = IW'($urandom);
        cmd_dst   = IW'($urandom);
        cmd_imm   = DW'($urandom);
    endtask

    task automatic check_bank();
        for (int i = 0; i < NREG; i++) check_eq("bank_vs_model", 32'(bank[i]), 32'(model[i]));
    endtask

    // Issues one command at a negedge and checks the whole transfer timeline against the rules.
    task automatic issue(input logic [1:0] op, input int src, input int dst,
                         input logic [DW-1:0] imm, input int hold);
        bit rej;
        logic [NREG-1:0] exp_oe;
        logic [NREG-1:0] exp_le;
        rej = (op == 2'd1 && dst >= NREG) || (op == 2'd2 && (src >= NREG || dst >= NREG)) ||
              (op == 2'd3 && src >= NREG);
        check_eq("ready_before", 32'(cmd_ready), 32'(1));
        cmd_valid = 1'b1; cmd_op = op; cmd_src = IW'(src); cmd_dst = IW'(dst); cmd_imm = imm;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        if (op == 2'd0 || rej) begin
            check_eq("err_pulse", 32'(err), 32'(rej));
            check_eq("ready_stays", 32'(cmd_ready), 32'(1));
            check_eq("oe_idle", 32'(oe_n), 32'(ALL1));
            check_eq("le_idle", 32'(le), 32'(0));
            check_eq("drive_idle", 32'(bus_drive_en), 32'(0));
            @(negedge clk);
            check_eq("err_clear", 32'(err), 32'(0));
            return;
        end
        exp_oe = ALL1;
        if (op != 2'd1) exp_oe[src] = 1'b0;
        exp_le = '0;
        if (op != 2'd3) exp_le[dst] = 1'b1;
        for (int ph = 0; ph < 2; ph++) begin
            check_eq(ph == 0 ? "drive_en_d" : "drive_en_l", 32'(bus_drive_en), 32'(op == 2'd1));
            if (op == 2'd1) check_eq("bus_out", 32'(bus_out), 32'(imm));
            check_eq(ph == 0 ? "oe_drive" : "oe_load", 32'(oe_n), 32'(exp_oe));
            check_eq(ph == 0 ? "le_drive" : "le_load", 32'(le), ph == 0 ? 32'(0) : 32'(exp_le));
            check_eq("ready_busy", 32'(cmd_ready), 32'(0));
            junk();
            @(negedge clk);
        end
        for (int t = 0; t < TURN; t++) begin
            check_eq("oe_release", 32'(oe_n), 32'(ALL1));
            check_eq("le_release", 32'(le), 32'(0));
            check_eq("drive_release", 32'(bus_drive_en), 32'(0));
            check_eq("ready_release", 32'(cmd_ready), 32'(0));
            check_eq("rsp_release", 32'(rsp_valid), 32'(0));
            junk();
            @(negedge clk);
        end
        if (op == 2'd1) model[dst] = imm;
        if (op == 2'd2) model[dst] = model[src];
        if (op != 2'd3) begin
            cmd_valid = 1'b0;
            check_eq("ready_after", 32'(cmd_ready), 32'(1));
        end else begin
            for (int h = 0; h <= hold; h++) begin
                check_eq("rsp_valid", 32'(rsp_valid), 32'(1));
                check_eq("rsp_data", 32'(rsp_data), 32'(model[src]));
                check_eq("ready_resp", 32'(cmd_ready), 32'(0));
                junk();
                if (h == hold) rsp_ready = 1'b1;
                @(negedge clk);
            end
            cmd_valid = 1'b0;
            rsp_ready = 1'b0;
            check_eq("rsp_drop", 32'(rsp_valid), 32'(0));
            check_eq("ready_after_rsp", 32'(cmd_ready), 32'(1));
        end
        check_bank();
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_op = '0; cmd_src = '0; cmd_dst = '0; cmd_imm = '0;
        rsp_ready = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_oe", 32'(oe_n), 32'(ALL1));
        check_eq("rst_le", 32'(le), 32'(0));
        check_eq("rst_drive", 32'(bus_drive_en), 32'(0));
        check_eq("rst_bus_out", 32'(bus_out), 32'(0));
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check_eq("rst_rsp_data", 32'(rsp_data), 32'(0));
        check_eq("rst_err", 32'(err), 32'(0));
        reset = 1'b1;
        @(negedge clk);
        check_eq("ready_after_reset", 32'(cmd_ready), 32'(1));

        issue(2'd1, 0, 0, 2'b01, 0);
        issue(2'd1, 0, 1, 2'b11, 0);
        issue(2'd1, 0, 2, 2'b00, 0);
        issue(2'd1, 0, 2, 2'b10, 0);
        issue(2'd2, 1, 2, 2'b00, 0);
        issue(2'd3, 2, 0, 2'b00, 0);
        issue(2'd3, 0, 0, 2'b00, 4);
        issue(2'd2, 3, 1, 2'b00, 0);
        issue(2'd1, 0, 3, 2'b01, 0);
        issue(2'd1, 0, 1, 2'b10, 0);
        issue(2'd0, 0, 0, 2'b00, 0);
        issue(2'd2, 1, 1, 2'b00, 0);
        issue(2'd3, 1, 0, 2'b00, 1);

        // Asynchronous reset during DRIVE abandons the load.
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_src = '0; cmd_dst = '0; cmd_imm = ~model[0];
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check_eq("mid_drive_en", 32'(bus_drive_en), 32'(1));
        reset = 1'b0;
        #1;
        check_eq("async_drive", 32'(bus_drive_en), 32'(0));
        check_eq("async_oe", 32'(oe_n), 32'(ALL1));
        check_eq("async_le", 32'(le), 32'(0));
        check_eq("async_bus_out", 32'(bus_out), 32'(0));
        check_eq("async_ready", 32'(cmd_ready), 32'(0));
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("ready_after_abort", 32'(cmd_ready), 32'(1));
        check_bank();

        repeat (120) begin
            issue(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  DW'($urandom), int'($urandom_range(0, 4)));
        end
        for (int i = 0; i < NREG; i++) issue(2'd3, i, 0, 2'b00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dreg_bus_sequencer.md
Name: dreg_bus_sequencer

Overview:
- Bus-master controller for a bank of NREG 2-bit tri-state data registers that share one DW-bit bus.
- Accepts host commands: load immediate, register-to-register move, and register read-back.
- Generates each register's load enable (E1/E2 pair) and active-low output enable (OE1/OE2 pair) with a guaranteed turnaround gap, so two drivers are never on the bus at once.
- Sits between the ALU control path and the register bank, and is the bank's only source of enables.

Parameters:
- NREG, 4, number of registers on the bus (2..16).
- DW, 2, bus and register data width.
- IW, 2, index width; must satisfy 2**IW >= NREG.
- TURN, 1, dead cycles after every transfer (1..3) with no bus driver enabled.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE).
- cmd_op  in  2  command: 00 NOP, 01 LOADI, 10 MOVE, 11 READ.
- cmd_src  in  IW  source register index (MOVE, READ).
- cmd_dst  in  IW  destination register index (LOADI, MOVE).
- cmd_imm  in  DW  immediate data (LOADI).
- le  out  NREG  per-register load enable; drives E1 and E2.
- oe_n  out  NREG  per-register active-low output enable; drives OE1 and OE2.
- bus_drive_en  out  1  sequencer drives bus_out onto the bus.
- bus_out  out  DW  sequencer bus data.
- bus_in  in  DW  resolved bus value.
- rsp_valid  out  1  READ result available.
- rsp_data  out  DW  READ result.
- rsp_ready  in  1  host accepts the result.
- err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous, legal mid-transfer):
  - state=IDLE, le=0, oe_n=all 1s, bus_drive_en=0, bus_out=0, rsp_valid=0, rsp_data=0, err=0.
  - cmd_ready=1 after the first clock edge with reset=1.
  - A transfer in flight is abandoned; the bank sees no driver and no load.
- Accept: cmd_valid & cmd_ready at a rising edge, in IDLE only. Capture op, src, dst, imm.
- NOP: accepted and consumed, stays in IDLE, no bus activity.
- Reject: an index used by the op that is >= NREG.
  - Command consumed, err=1 for exactly the next cycle, state stays IDLE.
  - No enable toggles.
- States: IDLE -> DRIVE -> LOAD -> RELEASE(TURN cycles) -> IDLE, or -> RESP -> IDLE for READ.
- DRIVE (1 cycle, the cycle after accept):
  - LOADI: bus_drive_en=1, bus_out=imm.
  - MOVE and READ: oe_n[src]=0.
  - le=0.
- LOAD (1 cycle):
  - Same driver is held.
  - LOADI and MOVE: le[dst]=1 for this cycle only; the destination captures at the closing edge.
  - READ: le=0; rsp_data <= bus_in at the closing edge.
- RELEASE (exactly TURN cycles): oe_n=all 1s, bus_drive_en=0, le=0.
- After RELEASE:
  - LOADI and MOVE go to IDLE.
  - READ goes to RESP.
- RESP: rsp_valid=1 and rsp_data stable until rsp_ready=1 is sampled; then rsp_valid=0 next cycle and state=IDLE.
- MOVE with src==dst is legal: the register reloads its own value.
- Latency, accept edge to cmd_ready high again:
  - LOADI and MOVE: 2+TURN cycles.
  - READ: 2+TURN cycles plus RESP wait.
- Invariants, every cycle:
  - At most one of {bus_drive_en, any oe_n low} is active.
  - At most one le bit is high.
  - le is never high unless a driver is enabled in the same cycle.
  - Driver changes always pass through an all-released cycle.
- Changes on cmd_* while not accepting are ignored.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, release -> oe_n=4'b1111, le=0, bus_drive_en=0, cmd_ready=1; reasserting reset mid-DRIVE forces the same values immediately, without waiting for a clock edge.
- LOADI: op=01, dst=2, imm=2'b10 (TURN=1) -> DRIVE: bus_drive_en=1, bus_out=10; LOAD: le=4'b0100; RELEASE: all off; cmd_ready high 3 cycles after accept.
- MOVE: preload r1=2'b11, op=10, src=1, dst=3 -> DRIVE: oe_n=4'b1101; LOAD: oe_n=4'b1101, le=4'b1000; RELEASE: oe_n=4'b1111; reading r3 afterwards returns 2'b11.
- READ with backpressure: r0=2'b01, op=11, src=0, rsp_ready=0 for 4 cycles -> rsp_valid=1 and rsp_data=01 stable throughout; rsp_ready=1 -> rsp_valid=0 and cmd_ready=1 next cycle.
- Reject: NREG=3, op=10, src=3 -> err pulses 1 cycle, oe_n and le never change, next LOADI accepted normally.
- Back-to-back random ops, TURN=2 -> bus-contention checker never fires, le one-hot-or-zero every cycle, 2-cycle release gap before each new driver, register model matches.
